// File: rtl/myproject_sdiv_pkg.sv
// rtl/myproject_sdiv_pkg.sv - shared widths, states and limits for the sequential signed divider
package myproject_sdiv_pkg;

  localparam int DEF_DIVIDEND_W = 26;
  localparam int DEF_DIVISOR_W  = 10;
  localparam int DEF_QUOT_W     = 16;

  // Partial remainder carries one extra bit so the trial subtraction never wraps.
  localparam int DEF_PR_W = DEF_DIVIDEND_W + 1;

  localparam logic [DEF_QUOT_W-1:0] QUOT_MAX = {1'b0, {(DEF_QUOT_W-1){1'b1}}};
  localparam logic [DEF_QUOT_W-1:0] QUOT_MIN = {1'b1, {(DEF_QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sdiv_state_t;

endpackage

// File: rtl/myproject_sdiv_step.sv
// rtl/myproject_sdiv_step.sv - one combinational radix-2 restoring division step
//   pr_in   : partial remainder before the step
//   bit_in  : next dividend bit (MSB first)
//   dmag    : divisor magnitude
//   pr_out  : partial remainder after the step
//   q_bit   : quotient bit produced by the step
module myproject_sdiv_step
  import myproject_sdiv_pkg::*;
#(
  parameter int PR_W      = DEF_PR_W,
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [PR_W-1:0]      pr_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] dmag,
  output logic [PR_W-1:0]      pr_out,
  output logic                 q_bit
);

  logic [PR_W-1:0] shifted;
  logic [PR_W:0]   diff;
  logic            unused_pr_msb;

  // The partial remainder stays below the divisor, so its MSB is always zero
  // and dropping it on the shift loses nothing.
  assign unused_pr_msb = pr_in[PR_W-1];
  assign shifted       = {pr_in[PR_W-2:0], bit_in};
  assign diff          = {1'b0, shifted} - {{(PR_W+1-DIVISOR_W){1'b0}}, dmag};
  assign q_bit         = ~diff[PR_W];
  assign pr_out        = q_bit ? diff[PR_W-1:0] : shifted;

endmodule

// File: rtl/myproject_sdiv_26s_10s_16_seq.sv
// rtl/myproject_sdiv_26s_10s_16_seq.sv - sequential signed divider, 26s / 10s -> 16s quotient, 10s remainder
//   ap_clk, ap_rst          : clock, async active-high reset
//   in_valid/in_ready       : operand handshake (dividend, divisor)
//   out_valid/out_ready     : result handshake
//   quotient, remainder     : signed results (quotient saturated)
//   div_by_zero, overflow   : result flags
module myproject_sdiv_26s_10s_16_seq
  import myproject_sdiv_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int QUOT_W     = DEF_QUOT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int PR_W  = DIVIDEND_W + 1;
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W-1){1'b0}}};
  // Magnitude limits: a positive result may reach Q_MAX, a negative one 2^(QUOT_W-1).
  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'(Q_MAX);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(Q_MIN);
  localparam logic [CNT_W-1:0]      CNT_TOP = CNT_W'(DIVIDEND_W - 1);

  sdiv_state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dd_mag;
  logic [DIVISOR_W-1:0]  dv_mag;
  logic                  dd_neg, dv_neg, dv_zero;
  logic [PR_W-1:0]       pr, pr_nxt;
  logic [DIVIDEND_W-1:0] qsr;
  logic                  q_bit;
  logic                  accept;
  logic                  unused_pr_hi;

  assign in_ready  = (state == IDLE) && !ap_rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // |remainder| < |divisor|, so only the low DIVISOR_W bits carry information.
  assign unused_pr_hi = |pr[PR_W-1:DIVISOR_W];

  myproject_sdiv_step #(
    .PR_W      (PR_W),
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .pr_in  (pr),
    .bit_in (dd_mag[cnt]),
    .dmag   (dv_mag),
    .pr_out (pr_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt         <= '0;
      dd_mag      <= '0;
      dv_mag      <= '0;
      dd_neg      <= 1'b0;
      dv_neg      <= 1'b0;
      dv_zero     <= 1'b0;
      pr          <= '0;
      qsr         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dd_neg  <= dividend[DIVIDEND_W-1];
          dv_neg  <= divisor[DIVISOR_W-1];
          dv_zero <= (divisor == '0);
          // Two's complement of the most negative value reads back correctly as unsigned.
          dd_mag  <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
          dv_mag  <= divisor[DIVISOR_W-1] ? -divisor : divisor;
          pr      <= '0;
          qsr     <= '0;
          cnt     <= CNT_TOP;
        end
        CALC: begin
          pr  <= pr_nxt;
          qsr <= {qsr[DIVIDEND_W-2:0], q_bit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (dv_zero) begin
            quotient    <= dd_neg ? Q_MIN : Q_MAX;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            div_by_zero <= 1'b0;
            remainder   <= dd_neg ? -pr[DIVISOR_W-1:0] : pr[DIVISOR_W-1:0];
            if (dd_neg ^ dv_neg) begin
              overflow <= (qsr > NEG_LIM);
              quotient <= (qsr > NEG_LIM) ? Q_MIN : -qsr[QUOT_W-1:0];
            end else begin
              overflow <= (qsr > POS_LIM);
              quotient <= (qsr > POS_LIM) ? Q_MAX : qsr[QUOT_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_26s_10s_16_seq.sv
// tb/tb_myproject_sdiv_26s_10s_16_seq.sv - self-checking bench for the sequential signed divider
module tb_myproject_sdiv_26s_10s_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] dividend = '0;
  logic [9:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [9:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_sdiv_26s_10s_16_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  typedef struct {
    logic [25:0] dd;
    logic [9:0]  dv;
    logic [15:0] q;
    logic [9:0]  r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [25:0] dd, input logic [9:0] dv, input logic [15:0] q,
                         input logic [9:0] r, input logic dz, input logic ov);
    vec_t v;
    v.dd = dd; v.dv = dv; v.q = q; v.r = r; v.dz = dz; v.ov = ov;
    vecs.push_back(v);
  endtask

  // Reference: exact integer division with truncation toward zero, then saturation.
  task automatic model(input logic [25:0] a_raw, input logic [9:0] b_raw,
                       output logic [15:0] q, output logic [9:0] r,
                       output logic dz, output logic ov);
    longint a, b, qt, rt;
    a = longint'($signed(a_raw));
    b = longint'($signed(b_raw));
    if (b == 0) begin
      q = (a >= 0) ? 16'h7FFF : 16'h8000;
      r = '0; dz = 1'b1; ov = 1'b0;
    end else begin
      qt = a / b;
      rt = a % b;
      dz = 1'b0;
      ov = (qt > 32767) || (qt < -32768);
      if (qt > 32767) qt = 32767;
      if (qt < -32768) qt = -32768;
      q = 16'(qt);
      r = 10'(rt);
    end
  endtask

  task automatic start_op(input logic [25:0] dd, input logic [9:0] dv);
    int waited = 0;
    @(negedge ap_clk);
    while (!in_ready && waited < 60) begin
      @(negedge ap_clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(posedge ap_clk);
      #1 lat++;
      if (out_valid) break;
    end
  endtask

  task automatic finish_op(input string tag, input logic [15:0] q, input logic [9:0] r,
                           input logic dz, input logic ov);
    int lat;
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd27);
    @(negedge ap_clk);
    chk({tag, "_quotient"}, 32'(quotient), 32'(q));
    chk({tag, "_remainder"}, 32'(remainder), 32'(r));
    chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(dz));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] eq;
    logic [9:0]  er;
    logic        edz, eov;
    logic [25:0] rdd;
    logic [9:0]  rdv;

    add_vec(26'd1000,          10'd7,           16'h008E, 10'd6,   1'b0, 1'b0);
    add_vec(-26'sd1000,        10'd7,           16'hFF72, 10'h3FA, 1'b0, 1'b0);
    add_vec(26'd1000,          -10'sd7,         16'hFF72, 10'd6,   1'b0, 1'b0);
    add_vec(-26'sd1000,        -10'sd7,         16'h008E, 10'h3FA, 1'b0, 1'b0);
    add_vec(26'd5,             10'd0,           16'h7FFF, 10'd0,   1'b1, 1'b0);
    add_vec(-26'sd5,           10'd0,           16'h8000, 10'd0,   1'b1, 1'b0);
    add_vec(26'd0,             10'd0,           16'h7FFF, 10'd0,   1'b1, 1'b0);
    add_vec(26'd1000000,       10'd3,           16'h7FFF, 10'd1,   1'b0, 1'b1);
    add_vec(26'h2000000,       -10'sd1,         16'h7FFF, 10'd0,   1'b0, 1'b1);
    add_vec(26'h2000000,       10'd1,           16'h8000, 10'd0,   1'b0, 1'b1);
    add_vec(-26'sd32768,       10'd1,           16'h8000, 10'd0,   1'b0, 1'b0);
    add_vec(26'd32768,         -10'sd1,         16'h8000, 10'd0,   1'b0, 1'b0);
    add_vec(26'd32767,         10'd1,           16'h7FFF, 10'd0,   1'b0, 1'b0);
    add_vec(26'd1000,          10'h200,         16'hFFFF, 10'd488, 1'b0, 1'b0);

    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      start_op(vecs[i].dd, vecs[i].dv);
      finish_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
    end

    for (int i = 0; i < 40; i++) begin
      rdd = 26'($urandom);
      rdv = 10'($urandom);
      case ($urandom_range(0, 7))
        0: rdv = '0;
        1, 2: rdv = 10'($signed(4'($urandom)));
        3: rdd = 26'($signed(18'($urandom)));
        default: ;
      endcase
      model(rdd, rdv, eq, er, edz, eov);
      start_op(rdd, rdv);
      finish_op($sformatf("rnd%0d", i), eq, er, edz, eov);
    end

    // Backpressure: 100/9 held for 10 cycles while operand pulses are offered.
    begin
      int lat;
      start_op(26'd100, 10'd9);
      wait_valid(lat);
      chk("bp_latency", 32'(lat), 32'd27);
      for (int c = 0; c < 10; c++) begin
        @(negedge ap_clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_quotient", 32'(quotient), 32'd11);
        chk("bp_remainder", 32'(remainder), 32'd1);
        in_valid = c[0];
        dividend = 26'($urandom);
        divisor  = 10'($urandom);
      end
      @(negedge ap_clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_in_ready_hs", 32'(in_ready), 32'd0);
      @(posedge ap_clk);
      #1 out_ready = 1'b0;
      chk("bp_in_ready_next", 32'(in_ready), 32'd1);
      chk("bp_out_valid_next", 32'(out_valid), 32'd0);
      start_op(26'd12, 10'd4);
      finish_op("bp_follow", 16'd3, 10'd0, 1'b0, 1'b0);
    end

    // Asynchronous reset during the tenth CALC iteration.
    start_op(26'd500, 10'd3);
    repeat (9) @(posedge ap_clk);
    #3 ap_rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    start_op(26'd99, -10'sd10);
    finish_op("after_rst", 16'hFFF7, 10'd9, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
